// File: rtl/mux8_rr_sched_if.sv
// Requester/consumer bundle for mux8_rr_sched; the lock signal exists only
// when MUX8_SCHED_LOCK_EN is defined.
interface mux8_rr_sched_if ();
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       y;
    logic       busy;
`ifdef MUX8_SCHED_LOCK_EN
    logic       lock;

    modport master (input req, din, lock, output gnt, sel, valid, y, busy);
    modport slave  (output req, din, lock, input gnt, sel, valid, y, busy);
`else
    modport master (input req, din, output gnt, sel, valid, y, busy);
    modport slave  (output req, din, input gnt, sel, valid, y, busy);
`endif
endinterface

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 1-bit lane among 8 requesters in bursts
// of up to BURST_LEN beats. Define MUX8_SCHED_LOCK_EN to add burst extension.
module mux8_rr_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux8_rr_sched_if.master  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] winner;
    logic       found;
    logic       beat;
    logic       last;

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[ptr_q + 3'(i)]) begin
                winner = ptr_q + 3'(i);
                found  = 1'b1;
            end
        end
    end

    assign beat = (state_q == GRANT) && bus.req[sel_q];

`ifdef MUX8_SCHED_LOCK_EN
    assign last = beat && !bus.lock && (cnt_q >= LAST_BEAT);
`else
    assign last = beat && (cnt_q == LAST_BEAT);
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    gnt_d   = 8'd1 << winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (beat && cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                // Release on a dropped request or on the final beat; the served
                // requester becomes lowest priority for the next scan.
                if (!bus.req[sel_q] || last) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + 3'd1;
                    sel_d   = '0;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = beat;
    assign bus.y     = beat & bus.din[sel_q];
    assign bus.busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched (BURST_LEN=4): per-cycle vectors with
// expected outputs queued on drive and compared mid-cycle.
module tb_mux8_rr_sched;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] din;
        logic       lock;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       y;
        logic       busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb_q[$];

    mux8_rr_sched_if bus ();

    mux8_rr_sched #(.BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [7:0] rq, logic [7:0] d, logic lk,
                                logic [7:0] g, logic [2:0] s, logic v, logic yy, logic b);
        vec_t t;
        t.rst = r;  t.req = rq; t.din = d;  t.lock = lk;
        t.gnt = g;  t.sel = s;  t.valid = v; t.y = yy; t.busy = b;
        return t;
    endfunction

    task automatic check(input string name);
        vec_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        if (bus.gnt !== e.gnt || bus.sel !== e.sel || bus.valid !== e.valid ||
            bus.y !== e.y || bus.busy !== e.busy) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h sel=%0d valid=%b y=%b busy=%b, want gnt=%h sel=%0d valid=%b y=%b busy=%b",
                     name, bus.gnt, bus.sel, bus.valid, bus.y, bus.busy,
                     e.gnt, e.sel, e.valid, e.y, e.busy);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then sample mid-cycle.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst     = v.rst;
        bus.req = v.req;
        bus.din = v.din;
`ifdef MUX8_SCHED_LOCK_EN
        bus.lock = v.lock;
`endif
        sb_q.push_back(v);
        #1;
        check(name);
    endtask

    vec_t t_reset[$];
    vec_t t_data[$];

    initial begin
        logic [7:0] rot_din;
        int s;

        // Reset-idle table: all outputs zero under reset and with no requests.
        for (int i = 0; i < 2; i++) t_reset.push_back(mk(1, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) t_reset.push_back(mk(0, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0));

        // Data-select table (ptr=1 on entry): requester 2 then 5, din=04.
        t_data.push_back(mk(0, 8'h24, 8'h04, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) t_data.push_back(mk(0, 8'h24, 8'h04, 0, 8'h04, 2, 1, 1, 1));
        t_data.push_back(mk(0, 8'h24, 8'h04, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) t_data.push_back(mk(0, 8'h24, 8'h04, 0, 8'h20, 5, 1, 0, 1));
        t_data.push_back(mk(0, 8'h00, 8'h04, 0, 8'h00, 0, 0, 0, 0));

        rst      = 1'b1;
        bus.req  = '0;
        bus.din  = '0;
`ifdef MUX8_SCHED_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(posedge clk);

        for (int i = 0; i < t_reset.size(); i++) apply(t_reset[i], "reset_idle");

        // Full rotation with every requester active, wrapping back to 0.
        rot_din = 8'hA5;
        apply(mk(0, 8'hFF, rot_din, 0, 8'h00, 0, 0, 0, 0), "rot_first_idle");
        for (int g = 0; g < 9; g++) begin
            s = g % 8;
            for (int b = 0; b < 4; b++)
                apply(mk(0, 8'hFF, rot_din, 0, 8'd1 << s, 3'(s), 1, rot_din[s], 1), "rot_beat");
            apply(mk(0, (g == 8) ? 8'h00 : 8'hFF, rot_din, 0, 8'h00, 0, 0, 0, 0), "rot_turnaround");
        end

        for (int i = 0; i < t_data.size(); i++) apply(t_data[i], "data_select");

        // Early release on requester 3 (ptr=6 on entry); ptr moves to 4 so 4 beats 3.
        apply(mk(0, 8'h08, 8'hFF, 0, 8'h00, 0, 0, 0, 0), "early_idle");
        apply(mk(0, 8'h08, 8'hFF, 0, 8'h08, 3, 1, 1, 1), "early_beat1");
        apply(mk(0, 8'h08, 8'hFF, 0, 8'h08, 3, 1, 1, 1), "early_beat2");
        apply(mk(0, 8'h10, 8'hFF, 0, 8'h08, 3, 0, 0, 1), "early_drop");
        apply(mk(0, 8'h18, 8'hFF, 0, 8'h00, 0, 0, 0, 0), "early_turnaround");
        apply(mk(0, 8'h18, 8'hFF, 0, 8'h10, 4, 1, 1, 1), "early_next_sel4");
        apply(mk(0, 8'h00, 8'hFF, 0, 8'h10, 4, 0, 0, 1), "early_drop4");
        apply(mk(0, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0), "early_done");

        // Reset mid-burst on requester 6; ptr must return to 0 so 0 beats 6.
        apply(mk(0, 8'h40, 8'hFF, 0, 8'h00, 0, 0, 0, 0), "rstmid_idle");
        apply(mk(0, 8'h40, 8'hFF, 0, 8'h40, 6, 1, 1, 1), "rstmid_beat1");
        apply(mk(1, 8'h40, 8'hFF, 0, 8'h40, 6, 1, 1, 1), "rstmid_beat2");
        apply(mk(0, 8'h41, 8'hFF, 0, 8'h00, 0, 0, 0, 0), "rstmid_after");
        apply(mk(0, 8'h41, 8'hFF, 0, 8'h01, 0, 1, 1, 1), "rstmid_ptr0");
        apply(mk(0, 8'h00, 8'hFF, 0, 8'h01, 0, 0, 0, 1), "rstmid_drop");
        apply(mk(0, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0), "rstmid_done");

`ifdef MUX8_SCHED_LOCK_EN
        // Lock holds requester 1 for 10 beats, releasing on the first unlocked beat.
        apply(mk(0, 8'h02, 8'hFF, 1, 8'h00, 0, 0, 0, 0), "lock_idle");
        for (int b = 0; b < 10; b++)
            apply(mk(0, 8'h02, 8'hFF, 1, 8'h02, 1, 1, 1, 1), "lock_beat");
        apply(mk(0, 8'h02, 8'hFF, 0, 8'h02, 1, 1, 1, 1), "lock_release_beat");
        apply(mk(0, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0), "lock_turnaround");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
Round-robin scheduler that shares one 1-bit output lane between 8 requesters through an internal 8:1 select.
- Grants one requester at a time for a bounded burst.
- Drives the select code, the one-hot grant and the muxed data.
- Sits between 8 bit-serial sources and a single downstream consumer.

Parameters:
BURST_LEN, 4, maximum valid beats per grant; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  8  req[i]=1: requester i has data; held until served
din  input  8  din[i] = current data bit of requester i
gnt  output 8  one-hot grant, registered; 0 when no grant
sel  output 3  binary index of granted requester, registered
valid  output 1  y carries a beat this cycle
y  output 1  muxed data: din[sel] when valid, else 0
busy  output 1  1 while in GRANT state
lock  input  1  present only with MUX8_SCHED_LOCK_EN; extends burst

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: gnt=0, sel=0, valid=0, y=0, busy=0. Internal state: state=IDLE, ptr=0, cnt=0.
- Reset mid-burst: takes effect at the next edge. Burst is aborted with no completion beat, and ptr returns to 0.
- States: IDLE and GRANT (2-state FSM, registered).
- IDLE with req==0: stay in IDLE; all outputs 0.
- IDLE with req!=0:
  - Pick the first set bit of req searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - At the edge: gnt=onehot(winner), sel=winner, cnt=0, state=GRANT.
  - Grant latency: 1 cycle from the first cycle req is sampled in IDLE.
- GRANT:
  - busy=1.
  - valid = req[sel], combinational from the registered sel.
  - y = valid ? din[sel] : 0, combinational.
  - cnt increments (saturating at 15) on each edge where valid=1.
- Release at an edge when either holds:
  - (a) req[sel]=0 in that cycle (early release; no beat that cycle), or
  - (b) valid=1 and cnt==BURST_LEN-1 (last beat).
- On release: ptr=(sel+1) mod 8 (sel=7 wraps to ptr=0); gnt=0; state=IDLE.
- Turnaround: exactly one IDLE cycle between consecutive grants, so back-to-back grants are separated by one cycle with gnt=0.
- Fairness:
  - The last-served requester has lowest priority on the next arbitration.
  - With all 8 requesting, each is served within 8 grants.
- Requests arriving during GRANT are not sampled until the next IDLE cycle. A req that rises and falls entirely within a grant is lost (no queuing).
- Beat count per grant is 1..BURST_LEN. With BURST_LEN=1, every grant is exactly one beat followed by one idle cycle.
- req[i]=1 with gnt[i]=0 is ignored for data purposes; din of non-granted requesters never reaches y.

Optional Feature:
MUX8_SCHED_LOCK_EN
- Defined:
  - Port lock exists.
  - While lock=1 and req[sel]=1, release condition (b) is suppressed and the burst continues past BURST_LEN beats. cnt saturates at 15.
  - When lock=0 and cnt>=BURST_LEN-1 on a valid beat, release occurs at that edge.
  - Early release (a) always applies.
  - lock is ignored in IDLE.
- Undefined: no lock port; bursts are always capped at BURST_LEN.

Test Plan:
1. Reset idle: rst=1 for 2 cycles, then req=8'h00 for 5 cycles -> gnt=0, sel=0, valid=0, y=0, busy=0 throughout.
2. Full rotation (BURST_LEN=4): req=8'hFF held -> gnt 8'h01 for 4 valid cycles, 1 idle cycle, 8'h02 for 4, ..., 8'h80 for 4, idle, then wraps to 8'h01.
3. Data select: req=8'h24, din=8'h04 -> sel=2, y=1 for 4 beats, 1 idle cycle, then sel=5, y=0 for 4 beats, valid=1 on all 8 beats.
4. Early release: req=8'h08 for 2 cycles after grant, then req=8'h18 -> 2 beats on sel=3, idle cycle, next grant sel=4 (ptr=4), not 3.
5. Reset mid-burst: req=8'h40 granted, rst=1 on beat 2 -> next edge gnt=0, valid=0. After reset, req=8'h41 -> grant sel=0 (ptr reset to 0).
6. Lock (macro defined): req=8'h02, lock=1 for 10 beats -> 10 consecutive valid beats on sel=1. lock=0 with cnt>=3 -> release at that edge, then 1 idle cycle.
